jtag_tap: RTL and testbench

Synthesizable IEEE 1149.1 TAP controller that consumes the `tms`/`tck`/`tdi` stream driven by the JTAG VPI bench driver and returns `tdo` to it. It sits directly downstream of the driver, at the chip's JTAG pins. It provides the 16-state TAP FSM, the instruction register, BYPASS and IDCODE data registers, and a select/strobe interface to one external debug data register (the debug unit's scan chain).

---
 rtl/jtag_tap_pkg.sv | 12 +
 rtl/jtag_tap_fsm.sv | 36 +++
 rtl/jtag_tap.sv | 94 +++++++++
 tb/tb_jtag_tap.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encoding, default opcodes and IR capture pattern.
package jtag_tap_pkg;
   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;
   localparam logic [3:0]  IDCODE_OPCODE_DEF = 4'h2;
   localparam logic [3:0]  DEBUG_OPCODE_DEF  = 4'h8;
   localparam logic [3:0]  BYPASS_OPCODE_DEF = 4'hF;
   localparam logic [31:0] IDCODE_VALUE_DEF  = 32'h149511c3;
   localparam logic [1:0]  IR_CAPTURE        = 2'b01;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 16-state TAP controller, advanced on tck rise.
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       tck,
   input  logic       trst_n,
   input  logic       tms,
   output tap_state_e state
);
   tap_state_e state_nxt;
   always_ff @(posedge tck or negedge trst_n)
      if (!trst_n) state <= TLR;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      unique case (state)
         TLR:     state_nxt = tms ? TLR    : RTI;
         RTI:     state_nxt = tms ? SEL_DR : RTI;
         SEL_DR:  state_nxt = tms ? SEL_IR : CAP_DR;
         CAP_DR:  state_nxt = tms ? EX1_DR : SH_DR;
         SH_DR:   state_nxt = tms ? EX1_DR : SH_DR;
         EX1_DR:  state_nxt = tms ? UPD_DR : PAU_DR;
         PAU_DR:  state_nxt = tms ? EX2_DR : PAU_DR;
         EX2_DR:  state_nxt = tms ? UPD_DR : SH_DR;
         UPD_DR:  state_nxt = tms ? SEL_DR : RTI;
         SEL_IR:  state_nxt = tms ? TLR    : CAP_IR;
         CAP_IR:  state_nxt = tms ? EX1_IR : SH_IR;
         SH_IR:   state_nxt = tms ? EX1_IR : SH_IR;
         EX1_IR:  state_nxt = tms ? UPD_IR : PAU_IR;
         PAU_IR:  state_nxt = tms ? EX2_IR : PAU_IR;
         EX2_IR:  state_nxt = tms ? UPD_IR : SH_IR;
         UPD_IR:  state_nxt = tms ? SEL_DR : RTI;
         default: state_nxt = TLR;
      endcase
   end
endmodule

// File: rtl/jtag_tap.sv
// jtag_tap: TAP with IR, BYPASS, optional IDCODE DR and external debug DR select.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make it the reset opcode.
module jtag_tap
   import jtag_tap_pkg::*;
#(
   parameter int                IR_LEN        = 4,
   parameter logic [31:0]       IDCODE_VALUE  = IDCODE_VALUE_DEF,
   parameter logic [IR_LEN-1:0] IDCODE_OPCODE = IR_LEN'(IDCODE_OPCODE_DEF),
   parameter logic [IR_LEN-1:0] DEBUG_OPCODE  = IR_LEN'(DEBUG_OPCODE_DEF),
   parameter logic [IR_LEN-1:0] BYPASS_OPCODE = IR_LEN'(BYPASS_OPCODE_DEF)
)(
   input  logic tck,
   input  logic trst_n,
   input  logic tms,
   input  logic tdi,
   output logic tdo,
   output logic tdo_oe,
   input  logic debug_tdo,
   output logic debug_tdi,
   output logic debug_select,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic pause_dr,
   output logic test_logic_reset,
   output logic run_test_idle
);
   tap_state_e        state;
   logic [IR_LEN-1:0] ir_sr;
   logic [IR_LEN-1:0] ir;
   logic              byp;
   logic              dr_tdo;

   jtag_tap_fsm u_fsm (
      .tck    (tck),
      .trst_n (trst_n),
      .tms    (tms),
      .state  (state)
   );

   assign debug_tdi    = tdi;
   assign debug_select = ir == DEBUG_OPCODE;

`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_LEN-1:0] RESET_OPCODE = IDCODE_OPCODE;
   logic [31:0] idcode_sr;
   always_ff @(posedge tck or negedge trst_n)
      if (!trst_n) idcode_sr <= '0;
      else if (state == CAP_DR) idcode_sr <= IDCODE_VALUE;
      else if (state == SH_DR) idcode_sr <= {tdi, idcode_sr[31:1]};
   assign dr_tdo = debug_select ? debug_tdo : ir == IDCODE_OPCODE ? idcode_sr[0] : byp;
`else
   localparam logic [IR_LEN-1:0] RESET_OPCODE = BYPASS_OPCODE;
   logic unused_cfg;
   assign unused_cfg = ^{IDCODE_VALUE, IDCODE_OPCODE};
   assign dr_tdo = debug_select ? debug_tdo : byp;
`endif

   always_ff @(posedge tck or negedge trst_n)
      if (!trst_n) begin
         ir_sr <= '0;
         byp   <= 1'b0;
      end else begin
         if (state == CAP_IR) ir_sr <= IR_LEN'(IR_CAPTURE);
         else if (state == SH_IR) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
         if (state == CAP_DR) byp <= 1'b0;
         else if (state == SH_DR) byp <= tdi;
      end

   // Falling-edge side: latched IR, tdo and the state-decoded strobes.
   always_ff @(negedge tck or negedge trst_n)
      if (!trst_n) begin
         ir               <= RESET_OPCODE;
         tdo              <= 1'b0;
         tdo_oe           <= 1'b0;
         capture_dr       <= 1'b0;
         shift_dr         <= 1'b0;
         update_dr        <= 1'b0;
         pause_dr         <= 1'b0;
         test_logic_reset <= 1'b1;
         run_test_idle    <= 1'b0;
      end else begin
         if (state == TLR) ir <= RESET_OPCODE;
         else if (state == UPD_IR) ir <= ir_sr;
         tdo              <= state == SH_IR ? ir_sr[0] : state == SH_DR ? dr_tdo : 1'b0;
         tdo_oe           <= state == SH_IR || state == SH_DR;
         capture_dr       <= state == CAP_DR;
         shift_dr         <= state == SH_DR;
         update_dr        <= state == UPD_DR;
         pause_dr         <= state == PAU_DR;
         test_logic_reset <= state == TLR;
         run_test_idle    <= state == RTI;
      end
endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: table vectors, directed scans and random tms/tdi against a queue-based TAP model.
module tb_jtag_tap;
`ifdef JTAG_TAP_IDCODE_EN
   localparam bit         ID_EN  = 1'b1;
   localparam logic [3:0] RST_OP = 4'h2;
`else
   localparam bit         ID_EN  = 1'b0;
   localparam logic [3:0] RST_OP = 4'hF;
`endif
   localparam logic [31:0] IDV = 32'h149511c3;

   logic tck = 1'b0, trst_n = 1'b1, tms = 1'b1, tdi = 1'b0, debug_tdo = 1'b0;
   logic tdo, tdo_oe, debug_tdi, debug_select, capture_dr, shift_dr, update_dr, pause_dr;
   logic test_logic_reset, run_test_idle;
   int n_run = 0, n_fail = 0;

   jtag_tap dut (
      .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
      .debug_tdo(debug_tdo), .debug_tdi(debug_tdi), .debug_select(debug_select),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr), .pause_dr(pause_dr),
      .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle)
   );

   always #5 tck = ~tck;

   // State numbering follows the listed order: 0 TLR .. 15 UPD_IR.
   int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
   int         ms;
   bit         ir_q[$];
   bit         dr_q[$];
   logic [3:0] m_ir;
   logic       m_tdo;

   function automatic logic [3:0] ir_from_q();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = ir_q[i];
      return v;
   endfunction

   task automatic model_reset();
      ms = 0;
      ir_q = '{0, 0, 0, 0};
      dr_q = {};
      m_ir = RST_OP;
      m_tdo = 1'b0;
   endtask

   task automatic model_rise(input bit tms_v, input bit tdi_v);
      if (ms == 10) begin
         ir_q = {};
         for (int i = 0; i < 4; i++) ir_q.push_back(i == 0);
      end else if (ms == 11) begin
         void'(ir_q.pop_front());
         ir_q.push_back(tdi_v);
      end
      if (ms == 3) begin
         dr_q = {};
         if (m_ir == 4'h8) dr_q = {};
         else if (ID_EN && m_ir == 4'h2) for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
         else dr_q.push_back(1'b0);
      end else if (ms == 4 && dr_q.size() > 0) begin
         void'(dr_q.pop_front());
         dr_q.push_back(tdi_v);
      end
      ms = tms_v ? nxt1[ms] : nxt0[ms];
   endtask

   task automatic model_fall();
      if (ms == 0) m_ir = RST_OP;
      else if (ms == 15) m_ir = ir_from_q();
      m_tdo = ms == 11 ? ir_q[0] : ms == 4 ? (m_ir == 4'h8 ? debug_tdo : dr_q[0]) : 1'b0;
   endtask

   function automatic logic [9:0] outs();
      return {tdo, tdo_oe, debug_select, capture_dr, shift_dr, update_dr, pause_dr,
              test_logic_reset, run_test_idle, debug_tdi};
   endfunction

   function automatic logic [9:0] expv();
      return {m_tdo, ms == 4 || ms == 11, m_ir == 4'h8, ms == 3, ms == 4, ms == 8, ms == 6,
              ms == 0, ms == 1, tdi};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input bit tms_v, input bit tdi_v, input bit dt_v, input string nm);
      tms = tms_v;
      tdi = tdi_v;
      debug_tdo = dt_v;
      @(posedge tck);
      model_rise(tms_v, tdi_v);
      @(negedge tck);
      model_fall();
      #1;
      check({nm, " outs"}, 32'(outs()), 32'(expv()));
      check({nm, " ir"}, 32'(dut.ir), 32'(m_ir));
   endtask

   task automatic shift_ir(input logic [3:0] op, output logic [3:0] cap);
      step(1, 0, 0, "ir sel_dr");
      step(1, 0, 0, "ir sel_ir");
      step(0, 0, 0, "ir cap");
      step(0, 0, 0, "ir sh");
      cap[0] = tdo;
      for (int k = 0; k < 4; k++) begin
         step(k == 3, op[k], 0, "ir shift");
         if (k < 3) cap[k+1] = tdo;
      end
      step(1, 0, 0, "ir upd");
      step(0, 0, 0, "ir rti");
   endtask

   typedef struct {bit tms; bit tdi; bit e_tdo; bit e_oe; bit e_tlr;} vec_t;
   vec_t vt[14];

   logic [31:0] t, got;
   logic [7:0]  bv;
   logic [3:0]  cap;
   int n_cap, n_sh, n_upd, n_mir;

   initial begin
      vt = '{'{0,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,0}, '{0,0,0,0,0}, '{0,0,1,1,0},
             '{0,0,0,1,0}, '{0,0,0,1,0}, '{0,0,0,1,0}, '{1,0,0,0,0}, '{1,0,0,0,0},
             '{1,0,0,0,0}, '{1,0,0,0,0}, '{1,0,0,0,1}, '{0,0,0,0,0}};
      #1 trst_n = 1'b0;
      model_reset();
      #1;
      check("reset outs", 32'(outs()), 32'(10'b0000000100));
      check("reset ir", 32'(dut.ir), 32'(RST_OP));
      @(negedge tck);
      trst_n = 1'b1;
      #1;

      // IR capture reads 1,0,0,0 then an exit through TLR
      for (int i = 0; i < 14; i++) begin
         step(vt[i].tms, vt[i].tdi, 0, "vec");
         check($sformatf("vec%0d", i), 32'({tdo, tdo_oe, test_logic_reset}),
               32'({vt[i].e_tdo, vt[i].e_oe, vt[i].e_tlr}));
      end

      // IDCODE (or BYPASS when the IDCODE register is absent) after reset
      trst_n = 1'b0;
      #1 model_reset();
      trst_n = 1'b1;
      t = $urandom;
      step(0, 0, 0, "id rti");
      step(1, 0, 0, "id sel");
      step(0, 0, 0, "id cap");
      step(0, 0, 0, "id sh");
      got[0] = tdo;
      for (int k = 0; k < 32; k++) begin
         step(0, t[k], 0, "id shift");
         if (k < 31) got[k+1] = tdo;
      end
      check("idcode", got, ID_EN ? IDV : {t[30:0], 1'b0});
      check("idcode bit33", 32'(tdo), 32'(ID_EN ? t[0] : t[31]));
      step(1, 0, 0, "id ex1");
      step(1, 0, 0, "id upd");
      step(0, 0, 0, "id rti");

      // BYPASS: 0xA5 comes back one bit late behind the captured 0
      shift_ir(4'hF, cap);
      check("ir capture", 32'(cap), 32'h1);
      check("ir bypass", 32'(dut.ir), 32'hF);
      step(1, 0, 0, "byp sel");
      step(0, 0, 0, "byp cap");
      step(0, 0, 0, "byp sh");
      bv[0] = tdo;
      for (int k = 0; k < 8; k++) begin
         step(k == 7, 8'hA5 >> k, 0, "byp shift");
         if (k < 7) bv[k+1] = tdo;
      end
      check("bypass", 32'(bv), 32'h4A);
      step(1, 0, 0, "byp upd");
      step(0, 0, 0, "byp rti");

      // Debug DR select: strobe counts and tdo mirroring debug_tdo
      shift_ir(4'h8, cap);
      check("debug_select", 32'(debug_select), 32'h1);
      n_cap = 0; n_sh = 0; n_upd = 0; n_mir = 0;
      for (int k = 0; k < 11; k++) begin
         step(k == 0 || k == 8 || k == 9, 0, 1'($urandom), "dbg");
         n_cap += capture_dr;
         n_sh += shift_dr;
         n_upd += update_dr;
         if (shift_dr && tdo !== debug_tdo) n_mir++;
      end
      check("dbg counts", {8'(n_cap), 8'(n_sh), 8'(n_upd), 8'(n_mir)}, {8'd1, 8'd6, 8'd1, 8'd0});

      // Five tms=1 rises from SH_IR land in TLR with the reset opcode
      step(1, 0, 0, "tlr sel_dr");
      step(1, 0, 0, "tlr sel_ir");
      step(0, 0, 0, "tlr cap");
      step(0, 0, 0, "tlr sh");
      for (int k = 0; k < 4; k++) step(0, k == 3, 0, "tlr shift");
      for (int k = 0; k < 5; k++) step(1, 0, 0, "tlr five");
      check("tlr reached", 32'({test_logic_reset, debug_select}), 32'b10);
      check("tlr ir", 32'(dut.ir), 32'(RST_OP));

      // trst_n mid-shift aborts the scan at once
      step(0, 0, 0, "rst rti");
      step(1, 0, 0, "rst sel");
      step(0, 0, 0, "rst cap");
      step(0, 0, 0, "rst sh");
      for (int k = 0; k < 3; k++) step(0, 1, 0, "rst shift");
      tdi = 1'b0;
      trst_n = 1'b0;
      #1;
      check("rst mid outs", 32'(outs()), 32'(10'b0000000100));
      check("rst mid ir", 32'(dut.ir), 32'(RST_OP));
      model_reset();
      trst_n = 1'b1;

      // Random tms/tdi/debug_tdo with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 100) < 35, 1'($urandom), 1'($urandom), "rand");
         if ($urandom % 400 == 0) begin
            trst_n = 1'b0;
            #1 model_reset();
            check("rand rst", 32'(outs()), 32'(expv()));
            trst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
